seg_frame_rx: RTL and testbench

SEG_FRAME_RX -- requirements
Module: seg_frame_rx

---
 rtl/seg_frame_rx.sv | 188 ++++++++++++++++++
 tb/tb_seg_frame_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_rx.sv
// Seven-beat 7-segment frame receiver: decodes time value, date, month, day.
// Optional date/month range rejection under SEG_FRAME_RX_RANGE_CHK_EN.
module seg_frame_rx #(
    parameter int GAP_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_valid,
    input  logic       sof,
    input  logic [6:0] seg_in,
    output logic [6:0] bin_out,
    output logic [5:0] date_out,
    output logic [4:0] month_out,
    output logic [2:0] day_out,
    output logic       out_valid,
    output logic       err,
    output logic       abort,
    output logic       busy
);

    localparam int GW = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t        state;
    logic [2:0]    slot;
    logic [GW-1:0] gap_cnt;
    logic          err_lat;

    logic [3:0] d0, d1, d2, d3, d4, d5;

    logic       start;
    logic       accept;
    logic [2:0] beat_slot;
    logic [4:0] dec;
    logic       blank;
    logic [3:0] digit;
    logic       beat_bad;
    logic [6:0] bin_v;
    logic [6:0] date_v;
    logic [6:0] mon_v;
    logic       range_bad;
    logic       frame_bad;

    // Returns {legal, digit}; blank is handled by the caller.
    function automatic logic [4:0] seg_dec(input logic [6:0] p);
        case (p)
            7'h7E:   seg_dec = {1'b1, 4'd0};
            7'h30:   seg_dec = {1'b1, 4'd1};
            7'h6D:   seg_dec = {1'b1, 4'd2};
            7'h79:   seg_dec = {1'b1, 4'd3};
            7'h33:   seg_dec = {1'b1, 4'd4};
            7'h5B:   seg_dec = {1'b1, 4'd5};
            7'h5F:   seg_dec = {1'b1, 4'd6};
            7'h70:   seg_dec = {1'b1, 4'd7};
            7'h7F:   seg_dec = {1'b1, 4'd8};
            7'h7B:   seg_dec = {1'b1, 4'd9};
            default: seg_dec = 5'd0;
        endcase
    endfunction

    function automatic logic [6:0] tu(input logic [3:0] t,
                                      input logic [3:0] u);
        tu = {3'd0, t} * 7'd10 + {3'd0, u};
    endfunction

    always_comb begin
        start  = seg_valid && sof;
        accept = seg_valid && (sof || state == COLLECT);
        beat_slot = (state == COLLECT && !sof) ? slot : 3'd0;
        dec   = seg_dec(seg_in);
        blank = (seg_in == 7'd0);
        digit = blank ? 4'd0 : dec[3:0];
        // Blank is only legal in the odd (tens) slots 1, 3 and 5.
        if (blank)
            beat_bad = !beat_slot[0];
        else
            beat_bad = !dec[4] ||
                       (beat_slot == 3'd6 && dec[3:0] > 4'd6);
        bin_v  = tu(d1, d0);
        date_v = tu(d3, d2);
        mon_v  = tu(d5, d4);
    end

`ifdef SEG_FRAME_RX_RANGE_CHK_EN
    assign range_bad = (date_v == 7'd0) || (date_v > 7'd31) ||
                       (mon_v == 7'd0) || (mon_v > 7'd12);
`else
    logic unused_hi;
    assign unused_hi = ^{date_v[6], mon_v[6:5]};
    assign range_bad = 1'b0;
`endif

    assign frame_bad = err_lat || beat_bad || range_bad;
    assign busy      = (state == COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
            d2 <= 4'd0;
            d3 <= 4'd0;
            d4 <= 4'd0;
            d5 <= 4'd0;
        end else if (accept) begin
            case (beat_slot)
                3'd0:    d0 <= digit;
                3'd1:    d1 <= digit;
                3'd2:    d2 <= digit;
                3'd3:    d3 <= digit;
                3'd4:    d4 <= digit;
                3'd5:    d5 <= digit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= 3'd0;
            gap_cnt   <= '0;
            err_lat   <= 1'b0;
            bin_out   <= 7'd0;
            date_out  <= 6'd0;
            month_out <= 5'd0;
            day_out   <= 3'd0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            abort     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            abort     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    gap_cnt <= '0;
                    if (start) begin
                        err_lat <= beat_bad;
                        slot    <= 3'd1;
                        state   <= COLLECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        abort   <= 1'b1;
                        err_lat <= beat_bad;
                        slot    <= 3'd1;
                        gap_cnt <= '0;
                    end else if (seg_valid) begin
                        gap_cnt <= '0;
                        if (slot == 3'd6) begin
                            state <= DONE;
                            slot  <= 3'd0;
                            if (frame_bad) begin
                                err <= 1'b1;
                            end else begin
                                out_valid <= 1'b1;
                                bin_out   <= bin_v;
                                date_out  <= date_v[5:0];
                                month_out <= mon_v[4:0];
                                day_out   <= digit[2:0];
                            end
                        end else begin
                            err_lat <= err_lat || beat_bad;
                            slot    <= slot + 3'd1;
                        end
                    end else if (gap_cnt == GW'(GAP_MAX - 1)) begin
                        abort   <= 1'b1;
                        state   <= IDLE;
                        slot    <= 3'd0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_frame_rx.sv
// Directed-vector bench for seg_frame_rx.
// Expected values are hand-decoded from the segment patterns.
module tb_seg_frame_rx;

    localparam int GAP = 15;

    logic       clk;
    logic       rst;
    logic       seg_valid;
    logic       sof;
    logic [6:0] seg_in;
    logic [6:0] bin_out;
    logic [5:0] date_out;
    logic [4:0] month_out;
    logic [2:0] day_out;
    logic       out_valid;
    logic       err;
    logic       abort;
    logic       busy;

    int nvec;
    int nerr;

    seg_frame_rx #(.GAP_MAX(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (seg_valid),
        .sof       (sof),
        .seg_in    (seg_in),
        .bin_out   (bin_out),
        .date_out  (date_out),
        .month_out (month_out),
        .day_out   (day_out),
        .out_valid (out_valid),
        .err       (err),
        .abort     (abort),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames packed with slot 0 in the top seven bits.
    localparam logic [48:0] F31 =
        {7'h5B, 7'h33, 7'h70, 7'h30, 7'h79, 7'h7E, 7'h6D};
    localparam logic [48:0] FBAD2 =
        {7'h5B, 7'h33, 7'h01, 7'h30, 7'h79, 7'h7E, 7'h6D};
    localparam logic [48:0] F33 =
        {7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h79, 7'h30, 7'h30};
    localparam logic [48:0] FD7 =
        {7'h5B, 7'h33, 7'h70, 7'h30, 7'h79, 7'h7E, 7'h70};
    localparam logic [48:0] FBLK =
        {7'h30, 7'h00, 7'h30, 7'h00, 7'h30, 7'h00, 7'h7E};
    localparam logic [48:0] FBU =
        {7'h00, 7'h33, 7'h70, 7'h30, 7'h79, 7'h7E, 7'h6D};
    localparam logic [48:0] F59 =
        {7'h7B, 7'h5B, 7'h30, 7'h79, 7'h6D, 7'h30, 7'h5F};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic s, input logic [6:0] p);
        seg_valid = 1'b1;
        sof       = s;
        seg_in    = p;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        sof       = 1'b0;
        seg_in    = 7'd0;
    endtask

    task automatic send_from(input logic [48:0] f, input int k);
        for (int i = k; i < 7; i++)
            send(i == 0, f[48-7*i -: 7]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag,
                           input int b, input int d,
                           input int m, input int w);
        check({tag, ".bin"}, 32'(bin_out), b);
        check({tag, ".date"}, 32'(date_out), d);
        check({tag, ".month"}, 32'(month_out), m);
        check({tag, ".day"}, 32'(day_out), w);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst       = 1'b1;
        seg_valid = 1'b0;
        sof       = 1'b0;
        seg_in    = 7'd0;
        idle(2);
        chk_out("rst", 0, 0, 0, 0);
        check("rst.ov", 32'(out_valid), 0);
        check("rst.err", 32'(err), 0);
        check("rst.abort", 32'(abort), 0);
        check("rst.busy", 32'(busy), 0);
        rst = 1'b0;
        idle(1);

        send(1'b1, F31[48 -: 7]);
        check("f31.busy", 32'(busy), 1);
        send_from(F31, 1);
        check("f31.ov", 32'(out_valid), 1);
        check("f31.err", 32'(err), 0);
        check("f31.busy", 32'(busy), 0);
        chk_out("f31", 45, 17, 3, 2);

        send(1'b1, FBAD2[48 -: 7]);
        check("done_sof.abort", 32'(abort), 0);
        check("done_sof.busy", 32'(busy), 1);
        check("done_sof.ovdrop", 32'(out_valid), 0);
        send_from(FBAD2, 1);
        check("bad2.err", 32'(err), 1);
        check("bad2.ov", 32'(out_valid), 0);
        chk_out("bad2", 45, 17, 3, 2);
        idle(1);
        check("bad2.errpulse", 32'(err), 0);

        send_from(F33, 0);
`ifdef SEG_FRAME_RX_RANGE_CHK_EN
        check("f33.err", 32'(err), 1);
        check("f33.ov", 32'(out_valid), 0);
        chk_out("f33", 45, 17, 3, 2);
`else
        check("f33.err", 32'(err), 0);
        check("f33.ov", 32'(out_valid), 1);
        chk_out("f33", 0, 0, 13, 1);
`endif
        idle(1);

        send_from(FD7, 0);
        check("dow7.err", 32'(err), 1);
        check("dow7.ov", 32'(out_valid), 0);
        idle(1);

        send_from(FBLK, 0);
        check("blank.err", 32'(err), 0);
        check("blank.ov", 32'(out_valid), 1);
        chk_out("blank", 1, 1, 1, 0);
        idle(1);

        send_from(FBU, 0);
        check("blku.err", 32'(err), 1);
        check("blku.ov", 32'(out_valid), 0);
        idle(1);

        send(1'b1, 7'h7E);
        send(1'b0, 7'h7E);
        send(1'b0, 7'h7E);
        check("pre_abort", 32'(abort), 0);
        send(1'b1, F59[48 -: 7]);
        check("sof_abort", 32'(abort), 1);
        check("sof_abort.busy", 32'(busy), 1);
        send_from(F59, 1);
        check("f59.abort", 32'(abort), 0);
        check("f59.ov", 32'(out_valid), 1);
        check("f59.err", 32'(err), 0);
        chk_out("f59", 59, 31, 12, 6);
        idle(1);

        send(1'b1, 7'h30);
        send(1'b0, 7'h30);
        idle(GAP - 1);
        check("gap.early_abort", 32'(abort), 0);
        check("gap.early_busy", 32'(busy), 1);
        idle(1);
        check("gap.abort", 32'(abort), 1);
        check("gap.busy", 32'(busy), 0);
        idle(1);
        check("gap.abortpulse", 32'(abort), 0);
        for (int i = 0; i < 7; i++)
            send(1'b0, F31[48-7*i -: 7]);
        check("stray.busy", 32'(busy), 0);
        check("stray.ov", 32'(out_valid), 0);
        check("stray.err", 32'(err), 0);
        chk_out("stray", 59, 31, 12, 6);

        send(1'b1, 7'h5B);
        send(1'b0, 7'h33);
        send(1'b0, 7'h70);
        send(1'b0, 7'h30);
        rst = 1'b1;
        #1;
        chk_out("midrst", 0, 0, 0, 0);
        check("midrst.busy", 32'(busy), 0);
        check("midrst.ov", 32'(out_valid), 0);
        #2;
        rst = 1'b0;
        idle(1);
        check("midrst.err", 32'(err), 0);
        check("midrst.abort", 32'(abort), 0);
        send_from(F31, 0);
        check("post_rst.ov", 32'(out_valid), 1);
        check("post_rst.err", 32'(err), 0);
        chk_out("post_rst", 45, 17, 3, 2);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
